pwm_timer_ctrl: RTL and testbench

- Sequencing and configuration controller for one pwm_comparator channel.
- Owns the period counter and drives CNT to the comparator.
- Holds the CCR, DELAY and PERIOD values in shadow registers written over a simple register interface.
- Presents active CCR/DELAY/PERIOD and ENABLE to the comparator, and applies shadow updates only at period boundaries so no runt or glitched pulse is ever produced.

---
 rtl/pwm_timer_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pwm_timer_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_timer_ctrl.sv
// Period counter, shadow/active register set and run-control FSM for one pwm_comparator channel.
// Optional one-pulse mode (CTRL bit 4) is built only when PWM_ONE_PULSE_EN is defined.
//
// state | meaning
// IDLE  | stopped, CNT=0, ENABLE=0, waiting for START
// LOAD  | one-cycle unconditional shadow->active copy before running
// RUN   | counting, wrap copies dirty shadows, STOP/ABORT/FORCE_UPD honoured
// DRAIN | counting until the next wrap, then IDLE; only ABORT honoured
module pwm_timer_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] ccr,
  output logic [WIDTH-1:0] delay,
  output logic [WIDTH-1:0] period,
  output logic             enable,
  output logic             busy,
  output logic             period_evt,
  output logic             update_evt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] sh_period, sh_ccr, sh_delay;
  logic             dirty;
  logic             copy;
  logic             pevt_nxt;
  logic             ctrl_wr, cmd_start, cmd_stop, cmd_abort, cmd_force;
  logic             wrap;
  logic [WIDTH-1:0] cnt_step;
  logic             opm_stop;

  assign ctrl_wr   = wr_en && (wr_addr == 2'd0);
  assign cmd_start = ctrl_wr && wr_data[0];
  assign cmd_stop  = ctrl_wr && wr_data[1];
  assign cmd_abort = ctrl_wr && wr_data[2];
  assign cmd_force = ctrl_wr && wr_data[3];

  // Wrap is modulo the active period; a zero period parks the counter at 0.
  assign wrap     = (period != '0) && (cnt == period - ONE);
  assign cnt_step = ((period == '0) || wrap) ? '0 : cnt + ONE;

`ifdef PWM_ONE_PULSE_EN
  logic opm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opm <= 1'b0;
    end else if (ctrl_wr) begin
      opm <= wr_data[4];
    end
  end

  assign opm_stop = opm;
`else
  assign opm_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ccr        <= '0;
      delay      <= '0;
      period     <= '0;
      sh_period  <= '0;
      sh_ccr     <= '0;
      sh_delay   <= '0;
      dirty      <= 1'b0;
      period_evt <= 1'b0;
      update_evt <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      period_evt <= pevt_nxt;
      update_evt <= copy;
      // The copy takes pre-edge shadow values; a coincident write keeps dirty set.
      if (copy) begin
        period <= sh_period;
        ccr    <= sh_ccr;
        delay  <= sh_delay;
      end
      if (wr_en) begin
        case (wr_addr)
          2'd1:    sh_period <= wr_data;
          2'd2:    sh_ccr    <= wr_data;
          2'd3:    sh_delay  <= wr_data;
          default: ;
        endcase
      end
      if (wr_en && (wr_addr != 2'd0)) begin
        dirty <= 1'b1;
      end else if (copy) begin
        dirty <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    copy      = 1'b0;
    pevt_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (!cmd_abort && cmd_start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        copy      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cmd_abort) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cmd_stop) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = cnt_step;
          pevt_nxt  = wrap;
          copy      = wrap && dirty;
        end else if (cmd_force) begin
          copy    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt  = cnt_step;
          pevt_nxt = wrap;
          if (wrap && opm_stop) begin
            state_nxt = S_IDLE;
          end else begin
            copy = wrap && dirty;
          end
        end
      end
      S_DRAIN: begin
        if (cmd_abort) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt  = cnt_step;
          pevt_nxt = wrap;
          if (wrap) begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    enable = (state == S_RUN) || (state == S_DRAIN);
    busy   = (state != S_IDLE);
  end

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Directed bench for pwm_timer_ctrl: run/stop/abort sequencing, boundary-timed shadow updates,
// zero period, forced update, one-pulse mode (when PWM_ONE_PULSE_EN is defined) and async reset.
module tb_pwm_timer_ctrl;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [1:0]       wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] cnt, ccr, delay, period;
  logic             enable, busy, period_evt, update_evt;

  int n_chk = 0;
  int n_err = 0;

  pwm_timer_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cnt        (cnt),
    .ccr        (ccr),
    .delay      (delay),
    .period     (period),
    .enable     (enable),
    .busy       (busy),
    .period_evt (period_evt),
    .update_evt (update_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ccr", 32'(ccr), 0);
    chk("rst_pevt", 32'(period_evt), 0);
    #2 rst_n = 1'b1;
    tick();

    // configure and start: PERIOD=10 CCR=3 DELAY=2
    wr(2'd1, 16'd10);
    wr(2'd2, 16'd3);
    wr(2'd3, 16'd2);
    chk("shadow_no_effect", 32'(ccr), 0);
    wr(2'd0, 16'h0001);
    chk("load_busy", 32'(busy), 1);
    chk("load_enable", 32'(enable), 0);
    tick();
    chk("run_enable", 32'(enable), 1);
    chk("run_cnt0", 32'(cnt), 0);
    chk("run_ccr", 32'(ccr), 3);
    chk("run_delay", 32'(delay), 2);
    chk("run_period", 32'(period), 10);
    chk("run_uevt", 32'(update_evt), 1);
    for (int s = 1; s <= 20; s++) begin
      tick();
      chk("seq_cnt", 32'(cnt), 32'(s % 10));
      chk("seq_pevt", 32'(period_evt), (s % 10 == 0) ? 1 : 0);
    end

    // CCR write mid-period (lands at cnt 4->5)
    repeat (4) tick();
    wr(2'd2, 16'd7);
    chk("mid_cnt", 32'(cnt), 5);
    chk("mid_ccr_hold", 32'(ccr), 3);
    repeat (4) tick();
    chk("pre_wrap_ccr", 32'(ccr), 3);
    chk("pre_wrap_cnt", 32'(cnt), 9);
    tick();
    chk("wrap_cnt", 32'(cnt), 0);
    chk("wrap_ccr", 32'(ccr), 7);
    chk("wrap_uevt", 32'(update_evt), 1);
    chk("wrap_pevt", 32'(period_evt), 1);

    // CCR write landing exactly on the wrap edge
    repeat (9) tick();
    chk("edge_pre_cnt", 32'(cnt), 9);
    wr(2'd2, 16'd5);
    chk("edge_cnt", 32'(cnt), 0);
    chk("edge_ccr_hold", 32'(ccr), 7);
    chk("edge_uevt", 32'(update_evt), 0);
    repeat (9) tick();
    chk("edge_late_ccr", 32'(ccr), 7);
    tick();
    chk("edge_next_ccr", 32'(ccr), 5);
    chk("edge_next_uevt", 32'(update_evt), 1);

    // STOP -> DRAIN -> IDLE at wrap
    tick();
    wr(2'd0, 16'h0002);
    chk("drain_cnt", 32'(cnt), 2);
    chk("drain_enable", 32'(enable), 1);
    chk("drain_busy", 32'(busy), 1);
    repeat (7) tick();
    chk("drain_cnt9", 32'(cnt), 9);
    chk("drain_enable9", 32'(enable), 1);
    tick();
    chk("stop_cnt", 32'(cnt), 0);
    chk("stop_enable", 32'(enable), 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_pevt", 32'(period_evt), 1);
    tick();
    chk("idle_cnt", 32'(cnt), 0);

    // ABORT mid-run
    wr(2'd0, 16'h0001);
    tick();
    tick();
    tick();
    chk("abort_pre_cnt", 32'(cnt), 2);
    wr(2'd0, 16'h0004);
    chk("abort_cnt", 32'(cnt), 0);
    chk("abort_enable", 32'(enable), 0);
    chk("abort_busy", 32'(busy), 0);

    // zero period then FORCE_UPD to PERIOD=4
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h0001);
    tick();
    chk("p0_enable", 32'(enable), 1);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("p0_cnt", 32'(cnt), 0);
      chk("p0_pevt", 32'(period_evt), 0);
    end
    wr(2'd1, 16'd4);
    wr(2'd0, 16'h0008);
    chk("force_cnt", 32'(cnt), 0);
    chk("force_period", 32'(period), 4);
    chk("force_uevt", 32'(update_evt), 1);
    chk("force_pevt", 32'(period_evt), 0);
    repeat (3) tick();
    chk("force_cnt3", 32'(cnt), 3);
    tick();
    chk("force_wrap_cnt", 32'(cnt), 0);
    chk("force_wrap_pevt", 32'(period_evt), 1);

    // STOP|ABORT together: ABORT wins
    wr(2'd0, 16'h0006);
    chk("prio_busy", 32'(busy), 0);

    // one-pulse mode request with PERIOD=6
    wr(2'd1, 16'd6);
    wr(2'd0, 16'h0011);
    tick();
    repeat (5) tick();
    chk("opm_cnt5", 32'(cnt), 5);
    tick();
    chk("opm_wrap_cnt", 32'(cnt), 0);
    chk("opm_wrap_pevt", 32'(period_evt), 1);
`ifdef PWM_ONE_PULSE_EN
    chk("opm_busy", 32'(busy), 0);
    chk("opm_enable", 32'(enable), 0);
    tick();
    chk("opm_after_cnt", 32'(cnt), 0);
`else
    chk("cont_busy", 32'(busy), 1);
    chk("cont_enable", 32'(enable), 1);
    tick();
    chk("cont_after_cnt", 32'(cnt), 1);
    wr(2'd0, 16'h0004);
`endif

    // asynchronous reset mid-run at CNT=5
    wr(2'd1, 16'd10);
    wr(2'd0, 16'h0001);
    tick();
    repeat (5) tick();
    chk("arst_pre_cnt", 32'(cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_enable", 32'(enable), 0);
    chk("arst_ccr", 32'(ccr), 0);
    chk("arst_delay", 32'(delay), 0);
    chk("arst_period", 32'(period), 0);
    chk("arst_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
